// File: rtl/alu_issue.sv
// Command sequencer that drives a combinational ALU from registers, chains the
// result back into operand B for repeated passes, and returns the final result and flags.
module alu_issue #(
    parameter int WIDTH = 32,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [2:0]       alu_select,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q;
    logic [REP_W-1:0] rem_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_z_q;
    logic             rsp_n_q;
    logic             flag_z_q;
    logic             flag_n_q;
    logic             busy_q;

    // Acceptance is gated by reset so nothing is taken while the block is held in reset.
    assign cmd_ready  = rst_n && (state_q == IDLE);

    assign alu_select = op_q;
    assign alu_a      = a_q;
    assign alu_b      = acc_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_n      = rsp_n_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign busy       = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_z_q     <= 1'b0;
            rsp_n_q     <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        a_q     <= cmd_a;
                        acc_q   <= cmd_b;
                        rem_q   <= cmd_rep;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Each pass feeds the ALU result back in as the next operand B.
                    acc_q <= alu_out;
                    if (rem_q == '0) begin
                        rsp_data_q  <= alu_out;
                        rsp_z_q     <= alu_z;
                        rsp_n_q     <= alu_n;
                        flag_z_q    <= alu_z;
                        flag_n_q    <= alu_n;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        rem_q <= rem_q - REP_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a stub ALU closes the loop, a queue scoreboard
// holds expected responses, and immediate assertions check each observation.
module tb_alu_issue;

    localparam int W  = 32;
    localparam int RW = 4;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [RW-1:0] cmd_rep;
    logic [2:0]    alu_select;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_out;
    logic          alu_z;
    logic          alu_n;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_z;
    logic          rsp_n;
    logic          flag_z;
    logic          flag_n;
    logic          busy;

    typedef struct packed {
        logic [W-1:0] d;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    time  t_acc;

    alu_issue #(.WIDTH(W), .REP_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_rep(cmd_rep),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .flag_z(flag_z), .flag_n(flag_n),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            3'd0:    return b + a;
            3'd1:    return b - a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return b;
        endcase
    endfunction

    assign alu_out = alu_f(alu_select, alu_a, alu_b);
    assign alu_z   = (alu_out == '0);
    assign alu_n   = alu_out[W-1];

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int rep);
        exp_t         e;
        logic [W-1:0] acc;
        acc = b;
        for (int i = 0; i <= rep; i++) acc = alu_f(op, a, acc);
        e.d = acc;
        e.z = (acc == '0);
        e.n = acc[W-1];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_rep   = RW'(rep);
        sb.push_back(model(op, a, b, rep));
    endtask

    task automatic wait_accept();
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chkb("accept_wait", cmd_ready, 1'b1);
        t_acc = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int rep, input int hold);
        int           t = 0;
        logic [W-1:0] d0;
        exp_t         e;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chkb("rsp_wait", rsp_valid, 1'b1);
        chk("latency", W'(($time - t_acc) / 10), W'(rep + 2));
        d0 = rsp_data;
        repeat (hold) begin
            @(negedge clk);
            chkb("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, d0);
            chkb("hold_cmd_ready", cmd_ready, 1'b0);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chkb("resp_cmd_ready", cmd_ready, 1'b0);
        chk("rsp_data", rsp_data, e.d);
        chkb("rsp_z", rsp_z, e.z);
        chkb("rsp_n", rsp_n, e.n);
        chkb("flag_z", flag_z, e.z);
        chkb("flag_n", flag_n, e.n);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chkb("valid_drop", rsp_valid, 1'b0);
        chk("data_kept", rsp_data, e.d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_rep   = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chkb("rst_cmd_ready", cmd_ready, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chkb("rst_flag_z", flag_z, 1'b0);
        chk("rst_alu_select", W'(alu_select), '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chkb("rel_cmd_ready", cmd_ready, 1'b1);

        // Single add
        drive_cmd(OP_ADD, 32'd5, 32'd3, 0);
        wait_accept();
        chk("exec_alu_select", W'(alu_select), W'(OP_ADD));
        chk("exec_alu_a", alu_a, 32'd5);
        chk("exec_alu_b", alu_b, 32'd3);
        chkb("exec_busy", busy, 1'b1);
        collect(0, 0);

        // Repeated-add multiply, cmd_a wiggled during EXEC
        drive_cmd(OP_ADD, 32'd7, 32'd0, 5);
        wait_accept();
        cmd_a = 32'd1000;
        collect(5, 0);

        // Negative then zero results
        drive_cmd(OP_SUB, 32'd10, 32'd3, 0);
        wait_accept();
        collect(0, 0);
        drive_cmd(OP_SUB, 32'd4, 32'd4, 0);
        wait_accept();
        collect(0, 0);

        // Backpressure with a second command waiting
        drive_cmd(OP_ADD, 32'd2, 32'd3, 0);
        wait_accept();
        drive_cmd(OP_SUB, 32'd9, 32'd100, 1);
        collect(0, 3);
        chkb("bp_second_ready", cmd_ready, 1'b1);
        wait_accept();
        collect(1, 0);

        // Wrap-around
        drive_cmd(OP_ADD, 32'd1, 32'hFFFF_FFFF, 0);
        wait_accept();
        collect(0, 0);

        // Reset in the 4th EXEC cycle of a long command (not scored)
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_a     = 32'd1;
        cmd_b     = 32'd0;
        cmd_rep   = 4'd15;
        wait_accept();
        repeat (3) @(negedge clk);
        chkb("mid_busy", busy, 1'b1);
        chkb("mid_valid", rsp_valid, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chkb("mr_busy", busy, 1'b0);
        chkb("mr_cmd_ready", cmd_ready, 1'b0);
        chkb("mr_flag_z", flag_z, 1'b0);
        chkb("mr_flag_n", flag_n, 1'b0);
        chkb("mr_rsp_z", rsp_z, 1'b0);
        chk("mr_alu_b", alu_b, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chkb("mr_rel_ready", cmd_ready, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chkb("mr_no_rsp", seen, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
